// File: rtl/bpu_gshare.sv
// Gshare successor predictor: PHT indexed by PC^GHR, tagged direct-mapped BTB and a
// circular RAS, producing one aligned fetch block per handshake with GHR/RAS checkpoints.
module bpu_gshare #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          BTB_IDX     = 9,
    parameter int          TAG_LEN     = 8,
    parameter int          PHT_IDX     = 13,
    parameter int          GHR_LEN     = 8,
    parameter int          RAS_DEPTH   = 8,
    parameter logic [31:0] INIT_PC     = 32'h1c000000,
    localparam int         FW_B        = $clog2(FETCH_WIDTH),
    localparam int         RAS_B       = $clog2(RAS_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [31:0]            redir_addr_i,
    input  logic [GHR_LEN-1:0]     redir_ghr_i,
    input  logic [RAS_B-1:0]       redir_ras_ptr_i,
    input  logic                   upd_valid_i,
    input  logic [31:0]            upd_pc_i,
    input  logic                   upd_is_branch_i,
    input  logic [1:0]             upd_br_type_i,
    input  logic                   upd_taken_i,
    input  logic [31:0]            upd_target_i,
    input  logic [GHR_LEN-1:0]     upd_ghr_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            pc_o,
    output logic [FETCH_WIDTH-1:0] mask_o,
    output logic [FETCH_WIDTH-1:0] taken_o,
    output logic [31:0]            next_pc_o,
    output logic [GHR_LEN-1:0]     ghr_o,
    output logic [RAS_B-1:0]       ras_ptr_o
);

    localparam int BTB_ENT = 1 << BTB_IDX;
    localparam int PHT_ENT = 1 << PHT_IDX;

    localparam logic [1:0] BR_COND = 2'd0;
    localparam logic [1:0] BR_CALL = 2'd1;
    localparam logic [1:0] BR_RET  = 2'd2;

    typedef enum logic {S_INIT, S_RUN} state_t;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    state_t               state_p0, state_nxt;
    logic [PHT_IDX-1:0]   cnt_p0;
    logic [31:0]          pc_p0;
    logic [GHR_LEN-1:0]   ghr_p0;
    logic [RAS_B-1:0]     top_p0;

    logic [1:0]           pht      [PHT_ENT];
    logic [BTB_ENT-1:0]   btb_valid;
    logic [TAG_LEN-1:0]   btb_tag  [BTB_ENT];
    logic [1:0]           btb_type [BTB_ENT];
    logic [31:0]          btb_tgt  [BTB_ENT];
    logic [31:0]          ras      [RAS_DEPTH];

    logic [31:0]          base;
    int                   slot_off;
    logic [31:0]          spc    [FETCH_WIDTH];
    logic [BTB_IDX-1:0]   bidx   [FETCH_WIDTH];
    logic [PHT_IDX-1:0]   pidx   [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] live, hit, ptaken, is_cond;
    logic                 found;
    int                   k;
    logic                 ghr_upd;
    logic                 fire;
    logic                 k_call, k_ret;

    // ---- stage boundary: registered pc/GHR -> combinational prediction ----
    always_comb begin
        base     = {pc_p0[31:FW_B+2], {(FW_B+2){1'b0}}};
        slot_off = int'((pc_p0 >> 2) & 32'(FETCH_WIDTH - 1));
        found    = 1'b0;
        k        = 0;
        live     = '0;
        hit      = '0;
        ptaken   = '0;
        is_cond  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            spc[i]     = base + 32'(4 * i);
            bidx[i]    = spc[i][BTB_IDX+1:2];
            pidx[i]    = spc[i][PHT_IDX+1:2] ^ PHT_IDX'(ghr_p0);
            live[i]    = (i >= slot_off);
            hit[i]     = btb_valid[bidx[i]] && (btb_tag[bidx[i]] == spc[i][BTB_IDX+TAG_LEN+1:BTB_IDX+2])
                         && live[i];
            is_cond[i] = (btb_type[bidx[i]] == BR_COND);
            ptaken[i]  = hit[i] && (!is_cond[i] || pht[pidx[i]][1]);
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (ptaken[i] && !found) begin
                found = 1'b1;
                k     = i;
            end
        end
        mask_o  = '0;
        ghr_upd = found;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask_o[i] = live[i] && (!found || i <= k);
            if (mask_o[i] && hit[i] && is_cond[i]) ghr_upd = 1'b1;
        end
        taken_o = found ? (FETCH_WIDTH'(1) << k) : '0;
        k_call  = found && (btb_type[bidx[k]] == BR_CALL);
        k_ret   = found && (btb_type[bidx[k]] == BR_RET);
        if (!found)     next_pc_o = base + 32'(4 * FETCH_WIDTH);
        else if (k_ret) next_pc_o = ras[top_p0];
        else            next_pc_o = btb_tgt[bidx[k]];
    end

    assign valid_o   = (state_p0 == S_RUN);
    assign pc_o      = pc_p0;
    assign ghr_o     = ghr_p0;
    assign ras_ptr_o = top_p0;
    assign fire      = valid_o && ready_i && !flush_i;

    always_comb begin
        state_nxt = state_p0;
        if (state_p0 == S_INIT && cnt_p0 == '1) state_nxt = S_RUN;
    end

    // ---- stage boundary: fire/flush advance speculative state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= S_INIT;
            cnt_p0   <= '0;
            pc_p0    <= INIT_PC;
            ghr_p0   <= '0;
            top_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (state_p0 == S_INIT) cnt_p0 <= cnt_p0 + PHT_IDX'(1);
            if (flush_i) begin
                pc_p0  <= redir_addr_i;
                ghr_p0 <= redir_ghr_i;
                top_p0 <= redir_ras_ptr_i;
            end else if (fire) begin
                pc_p0 <= next_pc_o;
                if (ghr_upd) ghr_p0 <= GHR_LEN'({ghr_p0, found});
                if (k_call)     top_p0 <= top_p0 + RAS_B'(1);
                else if (k_ret) top_p0 <= top_p0 - RAS_B'(1);
            end
        end
    end

    logic [BTB_IDX-1:0] u_bidx;
    logic [TAG_LEN-1:0] u_tag;
    logic [PHT_IDX-1:0] u_pidx;
    logic               trn, btb_wr, btb_clr, pht_wr;
    logic               unused_upd;

    assign u_bidx     = upd_pc_i[BTB_IDX+1:2];
    assign u_tag      = upd_pc_i[BTB_IDX+TAG_LEN+1:BTB_IDX+2];
    assign u_pidx     = upd_pc_i[PHT_IDX+1:2] ^ PHT_IDX'(upd_ghr_i);
    assign trn        = valid_o && upd_valid_i;
    assign btb_wr     = trn && upd_is_branch_i && (upd_taken_i || upd_br_type_i != BR_COND);
    assign btb_clr    = trn && !upd_is_branch_i && (btb_tag[u_bidx] == u_tag);
    assign pht_wr     = trn && upd_is_branch_i && (upd_br_type_i == BR_COND);
    assign unused_upd = ^{upd_pc_i[31:BTB_IDX+TAG_LEN+2], upd_pc_i[1:0]};

    // ---- stage boundary: training and init-sweep writes ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (state_p0 == S_INIT) begin
            if (int'(cnt_p0) < BTB_ENT) btb_valid[cnt_p0[BTB_IDX-1:0]] <= 1'b0;
        end else if (btb_wr) begin
            btb_valid[u_bidx] <= 1'b1;
        end else if (btb_clr) begin
            btb_valid[u_bidx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_p0 == S_INIT)  pht[cnt_p0] <= 2'b01;
        else if (pht_wr)         pht[u_pidx] <= sat_ctr(pht[u_pidx], upd_taken_i);
        if (btb_wr) begin
            btb_tag[u_bidx]  <= u_tag;
            btb_type[u_bidx] <= upd_br_type_i;
            btb_tgt[u_bidx]  <= upd_target_i;
        end
        // Circular push: overflow silently overwrites the oldest return address.
        if (fire && k_call) ras[top_p0 + RAS_B'(1)] <= spc[k] + 32'd4;
    end

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: init sweep, BTB/PHT training, RAS push/pop and wrap,
// flush-vs-fire priority, unaligned entry and mid-run reset.
module tb_bpu_gshare;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] redir_addr_i;
    logic [7:0]  redir_ghr_i;
    logic [2:0]  redir_ras_ptr_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_is_branch_i;
    logic [1:0]  upd_br_type_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [7:0]  upd_ghr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [1:0]  mask_o;
    logic [1:0]  taken_o;
    logic [31:0] next_pc_o;
    logic [7:0]  ghr_o;
    logic [2:0]  ras_ptr_o;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] COND = 2'd0, CALL = 2'd1, RET = 2'd2, JUMP = 2'd3;

    always #5 clk = ~clk;

    bpu_gshare dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .redir_addr_i(redir_addr_i),
        .redir_ghr_i(redir_ghr_i), .redir_ras_ptr_i(redir_ras_ptr_i),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_branch_i(upd_is_branch_i),
        .upd_br_type_i(upd_br_type_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_ghr_i(upd_ghr_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
        .mask_o(mask_o), .taken_o(taken_o), .next_pc_o(next_pc_o), .ghr_o(ghr_o),
        .ras_ptr_o(ras_ptr_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic br, input logic [1:0] ty,
                         input logic tk, input logic [31:0] tgt, input logic [7:0] g);
        upd_valid_i = 1'b1; upd_pc_i = pc; upd_is_branch_i = br; upd_br_type_i = ty;
        upd_taken_i = tk; upd_target_i = tgt; upd_ghr_i = g;
        tick();
        upd_valid_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] addr, input logic [7:0] g, input logic [2:0] p);
        flush_i = 1'b1; redir_addr_i = addr; redir_ghr_i = g; redir_ras_ptr_i = p;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic fire();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        tick(); tick();
        tests++; if (valid_o !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", valid_o); fails++; end
        tests++; if (pc_o !== 32'h1c000000) begin $display("FAIL rst_pc: got %h want 1c000000", pc_o); fails++; end
        tests++; if (ghr_o !== 8'h00 || ras_ptr_o !== 3'd0) begin
            $display("FAIL rst_ckpt: ghr %h ptr %0d want 00/0", ghr_o, ras_ptr_o); fails++; end
        tests++; if (mask_o !== 2'b11 || taken_o !== 2'b00) begin
            $display("FAIL rst_mask: mask %b taken %b want 11/00", mask_o, taken_o); fails++; end
        rst_n = 1'b1;
        n = 0;
        while (valid_o !== 1'b1 && n < 9000) begin tick(); n++; end
        tests++; if (n !== 8192) begin $display("FAIL init_len: got %0d cycles want 8192", n); fails++; end
        tests++; if (pc_o !== 32'h1c000000 || mask_o !== 2'b11 || taken_o !== 2'b00) begin
            $display("FAIL run_first: pc %h mask %b taken %b want 1c000000/11/00", pc_o, mask_o, taken_o); fails++; end
        tests++; if (next_pc_o !== 32'h1c000008) begin
            $display("FAIL run_next: got %h want 1c000008", next_pc_o); fails++; end
    endtask

    task automatic test_jump();
        train(32'h1c000004, 1'b1, JUMP, 1'b1, 32'h1c000100, 8'h00);
        redirect(32'h1c000000, 8'h00, 3'd0);
        tests++; if (taken_o !== 2'b10 || mask_o !== 2'b11) begin
            $display("FAIL jump_taken: taken %b mask %b want 10/11", taken_o, mask_o); fails++; end
        tests++; if (next_pc_o !== 32'h1c000100) begin
            $display("FAIL jump_next: got %h want 1c000100", next_pc_o); fails++; end
        fire();
        tests++; if (pc_o !== 32'h1c000100 || ghr_o !== 8'h01) begin
            $display("FAIL jump_fire: pc %h ghr %h want 1c000100/01", pc_o, ghr_o); fails++; end
    endtask

    task automatic test_cond();
        train(32'h1c000000, 1'b1, COND, 1'b1, 32'h1c000040, 8'h00);
        train(32'h1c000000, 1'b1, COND, 1'b1, 32'h1c000040, 8'h00);
        redirect(32'h1c000000, 8'h00, 3'd0);
        tests++; if (mask_o !== 2'b01 || taken_o !== 2'b01 || next_pc_o !== 32'h1c000040) begin
            $display("FAIL cond_strong: mask %b taken %b next %h want 01/01/1c000040", mask_o, taken_o, next_pc_o); fails++; end
        tests++; if (ghr_o !== 8'h00) begin $display("FAIL cond_ghr: got %h want 00", ghr_o); fails++; end
        train(32'h1c000000, 1'b1, COND, 1'b0, 32'h1c000040, 8'h00);
        tests++; if (taken_o !== 2'b01) begin $display("FAIL cond_weak_t: taken %b want 01", taken_o); fails++; end
        train(32'h1c000000, 1'b1, COND, 1'b0, 32'h1c000040, 8'h00);
        tests++; if (taken_o !== 2'b10 || next_pc_o !== 32'h1c000100) begin
            $display("FAIL cond_weak_nt: taken %b next %h want 10/1c000100", taken_o, next_pc_o); fails++; end
        // From 01, four taken updates saturate at 11; one not-taken must leave it taken.
        for (int i = 0; i < 4; i++) train(32'h1c000000, 1'b1, COND, 1'b1, 32'h1c000040, 8'h00);
        train(32'h1c000000, 1'b1, COND, 1'b0, 32'h1c000040, 8'h00);
        tests++; if (taken_o !== 2'b01) begin $display("FAIL cond_sat: taken %b want 01", taken_o); fails++; end
    endtask

    task automatic test_ras();
        train(32'h1c000010, 1'b1, CALL, 1'b1, 32'h1c000200, 8'h00);
        train(32'h1c000200, 1'b1, RET, 1'b1, 32'h00000000, 8'h00);
        redirect(32'h1c000010, 8'h00, 3'd0);
        tests++; if (taken_o !== 2'b01 || next_pc_o !== 32'h1c000200) begin
            $display("FAIL call_pred: taken %b next %h want 01/1c000200", taken_o, next_pc_o); fails++; end
        fire();
        tests++; if (ras_ptr_o !== 3'd1 || next_pc_o !== 32'h1c000014) begin
            $display("FAIL ret_pred: ptr %0d next %h want 1/1c000014", ras_ptr_o, next_pc_o); fails++; end
        fire();
        tests++; if (ras_ptr_o !== 3'd0 || pc_o !== 32'h1c000014 || ghr_o !== 8'h03) begin
            $display("FAIL ret_fire: ptr %0d pc %h ghr %h want 0/1c000014/03", ras_ptr_o, pc_o, ghr_o); fails++; end
        train(32'h1c000020, 1'b1, CALL, 1'b1, 32'h1c000030, 8'h00);
        train(32'h1c000030, 1'b1, CALL, 1'b1, 32'h1c000030, 8'h00);
        redirect(32'h1c000020, 8'h00, 3'd0);
        fire();
        for (int i = 0; i < 8; i++) fire();
        tests++; if (ras_ptr_o !== 3'd1) begin $display("FAIL ras_wrap_ptr: got %0d want 1", ras_ptr_o); fails++; end
        redirect(32'h1c000200, 8'h00, 3'd1);
        tests++; if (next_pc_o !== 32'h1c000034) begin
            $display("FAIL ras_overwrite: got %h want 1c000034", next_pc_o); fails++; end
        redirect(32'h1c000200, 8'h00, 3'd0);
        fire();
        tests++; if (ras_ptr_o !== 3'd7 || pc_o !== 32'h1c000034) begin
            $display("FAIL ras_underflow: ptr %0d pc %h want 7/1c000034", ras_ptr_o, pc_o); fails++; end
    endtask

    task automatic test_flush_fire();
        ready_i = 1'b1;
        flush_i = 1'b1; redir_addr_i = 32'h1c000400; redir_ghr_i = 8'h5a; redir_ras_ptr_i = 3'd3;
        upd_valid_i = 1'b1; upd_pc_i = 32'h1c000404; upd_is_branch_i = 1'b1; upd_br_type_i = JUMP;
        upd_taken_i = 1'b1; upd_target_i = 32'h1c000500; upd_ghr_i = 8'h00;
        #1;
        tests++; if (valid_o !== 1'b1) begin $display("FAIL flush_valid: got %b want 1", valid_o); fails++; end
        tick();
        ready_i = 1'b0; flush_i = 1'b0; upd_valid_i = 1'b0;
        tests++; if (pc_o !== 32'h1c000400 || ghr_o !== 8'h5a || ras_ptr_o !== 3'd3) begin
            $display("FAIL flush_prio: pc %h ghr %h ptr %0d want 1c000400/5a/3", pc_o, ghr_o, ras_ptr_o); fails++; end
        tests++; if (taken_o !== 2'b10 || next_pc_o !== 32'h1c000500) begin
            $display("FAIL flush_train: taken %b next %h want 10/1c000500", taken_o, next_pc_o); fails++; end
        tick(); tick(); tick();
        tests++; if (pc_o !== 32'h1c000400 || next_pc_o !== 32'h1c000500 || ghr_o !== 8'h5a) begin
            $display("FAIL hold: pc %h next %h ghr %h want 1c000400/1c000500/5a", pc_o, next_pc_o, ghr_o); fails++; end
    endtask

    task automatic test_unaligned();
        train(32'h1c000004, 1'b0, COND, 1'b0, 32'h00000000, 8'h00);
        train(32'h1c000000, 1'b1, JUMP, 1'b1, 32'h1c000300, 8'h00);
        redirect(32'h1c000000, 8'h00, 3'd0);
        tests++; if (taken_o !== 2'b01 || next_pc_o !== 32'h1c000300) begin
            $display("FAIL slot0_jump: taken %b next %h want 01/1c000300", taken_o, next_pc_o); fails++; end
        redirect(32'h1c000004, 8'h00, 3'd0);
        tests++; if (mask_o !== 2'b10 || taken_o !== 2'b00 || next_pc_o !== 32'h1c000008) begin
            $display("FAIL unaligned: mask %b taken %b next %h want 10/00/1c000008", mask_o, taken_o, next_pc_o); fails++; end
    endtask

    task automatic test_mid_reset();
        redirect(32'h1c000400, 8'h5a, 3'd3);
        rst_n = 1'b0;
        #1;
        tests++; if (valid_o !== 1'b0 || pc_o !== 32'h1c000000 || ghr_o !== 8'h00 || ras_ptr_o !== 3'd0) begin
            $display("FAIL mid_reset: valid %b pc %h ghr %h ptr %0d want 0/1c000000/00/0", valid_o, pc_o, ghr_o, ras_ptr_o); fails++; end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        tests++; if (valid_o !== 1'b0) begin $display("FAIL reinit_valid: got %b want 0", valid_o); fails++; end
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; ready_i = 1'b0; upd_valid_i = 1'b0;
        redir_addr_i = '0; redir_ghr_i = '0; redir_ras_ptr_i = '0;
        upd_pc_i = '0; upd_is_branch_i = 1'b0; upd_br_type_i = '0; upd_taken_i = 1'b0;
        upd_target_i = '0; upd_ghr_i = '0;
        test_reset();
        test_jump();
        test_cond();
        test_ras();
        test_flush_fire();
        test_unaligned();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
